// File: rtl/gun_controller.sv
// Light-gun front end: synchronises and debounces the trigger, qualifies the photodetector,
// and runs the black-frame / target-frame shot sequence that yields one hit or miss per shot.
module gun_controller #(
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter bit TRIG_ACTIVE_LOW = 1'b1,
   parameter int DET_MIN_CYCLES  = 64,
   parameter int COOLDOWN_FRAMES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic gun_trigger,
   input  logic gun_photodetector,
   input  logic frame_start,
   input  logic enable,
   output logic black_screen,
   output logic target_screen,
   output logic shot,
   output logic hit,
   output logic miss,
   output logic busy
);
   localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int DET_W = $clog2(DET_MIN_CYCLES + 1);
   localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

   localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DET_W-1:0] DET_FULL    = DET_W'(DET_MIN_CYCLES);
   localparam logic [CD_W-1:0]  CD_LOAD     = CD_W'(COOLDOWN_FRAMES);
   localparam logic [CD_W-1:0]  CD_ONE      = CD_W'(1);
   localparam logic             PRESSED_RAW = TRIG_ACTIVE_LOW ? 1'b0 : 1'b1;

   typedef enum logic [2:0] {
      st_idle,
      st_wait,
      st_black,
      st_target,
      st_result,
      st_cooldown
   } state_t;

   state_t            state;
   logic [1:0]        trig_sync;
   logic [1:0]        det_sync;
   logic              trig_pressed;
   logic              deb_level;
   logic [DEB_W-1:0]  deb_cnt;
   logic              press_evt;
   logic [DET_W-1:0]  light_cnt;
   logic              light_seen;
   logic              lit_flag;
   logic              dark_fail;
   logic [CD_W-1:0]   cd_cnt;
   logic              abort;
   logic              is_hit;

   // Trigger chain resets to the pressed level so a trigger held through reset cannot fire.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trig_sync <= {2{PRESSED_RAW}};
         det_sync  <= 2'b00;
      end else begin
         trig_sync <= {trig_sync[0], gun_trigger};
         det_sync  <= {det_sync[0], gun_photodetector};
      end
   end

   assign trig_pressed = (trig_sync[1] == PRESSED_RAW);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_level <= 1'b1;
         deb_cnt   <= '0;
         press_evt <= 1'b0;
      end else begin
         press_evt <= 1'b0;
         if (trig_pressed == deb_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_level <= trig_pressed;
            deb_cnt   <= '0;
            press_evt <= trig_pressed;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   // Run length of consecutive light samples, restarted every frame so light cannot carry over.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         light_cnt <= '0;
      end else if (frame_start || !det_sync[1]) begin
         light_cnt <= '0;
      end else if (!light_seen) begin
         light_cnt <= light_cnt + 1'b1;
      end
   end

   assign light_seen = (light_cnt == DET_FULL);
   assign abort      = !enable && (state == st_wait || state == st_black || state == st_target);
   assign is_hit     = (lit_flag || light_seen) && !dark_fail;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= st_idle;
         black_screen  <= 1'b0;
         target_screen <= 1'b0;
         shot          <= 1'b0;
         hit           <= 1'b0;
         miss          <= 1'b0;
         busy          <= 1'b0;
         lit_flag      <= 1'b0;
         dark_fail     <= 1'b0;
         cd_cnt        <= '0;
      end else begin
         // NOTE: pulses default low here; a later non-blocking assignment in this block overrides it.
         shot <= 1'b0;
         hit  <= 1'b0;
         miss <= 1'b0;
         if (abort) begin
            state         <= st_idle;
            busy          <= 1'b0;
            black_screen  <= 1'b0;
            target_screen <= 1'b0;
            lit_flag      <= 1'b0;
            dark_fail     <= 1'b0;
         end else begin
            unique case (state)
               st_idle: begin
                  if (press_evt && enable) begin
                     shot  <= 1'b1;
                     busy  <= 1'b1;
                     state <= st_wait;
                  end
               end
               st_wait: begin
                  if (frame_start) begin
                     black_screen <= 1'b1;
                     state        <= st_black;
                  end
               end
               st_black: begin
                  if (light_seen) dark_fail <= 1'b1;
                  if (frame_start) begin
                     black_screen  <= 1'b0;
                     target_screen <= 1'b1;
                     state         <= st_target;
                  end
               end
               st_target: begin
                  if (light_seen) lit_flag <= 1'b1;
                  // Light seen on the closing frame_start still belongs to this frame.
                  if (frame_start) begin
                     target_screen <= 1'b0;
                     hit           <= is_hit;
                     miss          <= !is_hit;
                     state         <= st_result;
                  end
               end
               st_result: begin
                  lit_flag  <= 1'b0;
                  dark_fail <= 1'b0;
                  cd_cnt    <= CD_LOAD;
                  state     <= st_cooldown;
               end
               st_cooldown: begin
                  if (cd_cnt == '0) begin
                     busy  <= 1'b0;
                     state <= st_idle;
                  end else if (frame_start) begin
                     cd_cnt <= cd_cnt - 1'b1;
                     if (cd_cnt == CD_ONE) begin
                        busy  <= 1'b0;
                        state <= st_idle;
                     end
                  end
               end
               default: begin
                  busy  <= 1'b0;
                  state <= st_idle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gun_controller.sv
// Bench for gun_controller: history-based reference model compared every cycle,
// plus directed shot scenarios with hand-computed event counts.
module tb_gun_controller;
   localparam int DEB    = 16;
   localparam int DET    = 4;
   localparam int CD     = 2;
   localparam int FRAME  = 1000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic gun_trigger = 1'b1;
   logic gun_photodetector = 1'b0;
   logic frame_start = 1'b0;
   logic enable = 1'b1;
   logic black_screen, target_screen, shot, hit, miss, busy;

   gun_controller #(
      .DEBOUNCE_CYCLES(DEB),
      .TRIG_ACTIVE_LOW(1'b1),
      .DET_MIN_CYCLES(DET),
      .COOLDOWN_FRAMES(CD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .gun_trigger(gun_trigger),
      .gun_photodetector(gun_photodetector),
      .frame_start(frame_start),
      .enable(enable),
      .black_screen(black_screen),
      .target_screen(target_screen),
      .shot(shot),
      .hit(hit),
      .miss(miss),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", nm, act, exp, $time);
   endtask

   // frame_start: one cycle in every FRAME
   int fs_phase = 0;
   initial begin
      forever begin
         @(negedge clk);
         fs_phase = (fs_phase + 1) % FRAME;
         frame_start = (fs_phase == 0);
      end
   end

   // Reference model: the sampled pin histories decide debounce and light detection;
   // the shot sequence follows the frame-by-frame rules.
   typedef enum int {M_IDLE, M_WAIT, M_BLACK, M_TARGET, M_RESULT, M_COOL} mph_t;
   bit   tr_h [DEB+2];
   bit   dh   [DET+3];
   bit   fh   [DET+1];
   bit   m_level, m_pe, m_lit, m_dark;
   int   m_cd;
   mph_t m_ph = M_IDLE;
   bit   e_black = 0, e_target = 0, e_shot = 0, e_hit = 0, e_miss = 0, e_busy = 0;
   int   m_fs_total = 0, m_n_shot = 0, m_n_hit = 0, m_n_miss = 0;

   initial begin
      bit ls, pe, flip;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            for (int i = 0; i < DEB+2; i++) tr_h[i] = 1'b1;
            for (int i = 0; i < DET+3; i++) dh[i] = 1'b0;
            for (int i = 0; i < DET+1; i++) fh[i] = 1'b0;
            m_level = 1'b1; m_pe = 1'b0; m_lit = 1'b0; m_dark = 1'b0; m_cd = 0;
            m_ph = M_IDLE;
            e_black = 0; e_target = 0; e_shot = 0; e_hit = 0; e_miss = 0; e_busy = 0;
         end else begin
            for (int i = DEB+1; i > 0; i--) tr_h[i] = tr_h[i-1];
            tr_h[0] = !gun_trigger;
            for (int i = DET+2; i > 0; i--) dh[i] = dh[i-1];
            dh[0] = gun_photodetector;
            for (int i = DET; i > 0; i--) fh[i] = fh[i-1];
            fh[0] = frame_start;
            if (frame_start) m_fs_total++;
            // light seen: the last DET synchronised samples were light with no frame boundary among them
            ls = 1'b1;
            for (int j = 1; j <= DET; j++) if (!dh[j+2] || fh[j]) ls = 1'b0;
            pe = m_pe;
            m_pe = 1'b0;
            flip = 1'b1;
            for (int j = 0; j < DEB; j++) if (tr_h[j+2] == m_level) flip = 1'b0;
            if (flip) begin
               m_level = !m_level;
               m_pe = m_level;
            end
            e_shot = 0; e_hit = 0; e_miss = 0;
            if (!enable && (m_ph inside {M_WAIT, M_BLACK, M_TARGET})) begin
               m_ph = M_IDLE; e_black = 0; e_target = 0; e_busy = 0; m_lit = 0; m_dark = 0;
            end else begin
               case (m_ph)
                  M_IDLE:   if (pe && enable) begin e_shot = 1; e_busy = 1; m_ph = M_WAIT; m_n_shot++; end
                  M_WAIT:   if (frame_start) begin e_black = 1; m_ph = M_BLACK; end
                  M_BLACK: begin
                     if (ls) m_dark = 1;
                     if (frame_start) begin e_black = 0; e_target = 1; m_ph = M_TARGET; end
                  end
                  M_TARGET: begin
                     if (ls) m_lit = 1;
                     if (frame_start) begin
                        e_target = 0;
                        e_hit  = m_lit && !m_dark;
                        e_miss = !e_hit;
                        if (e_hit) m_n_hit++; else m_n_miss++;
                        m_ph = M_RESULT;
                     end
                  end
                  M_RESULT: begin m_lit = 0; m_dark = 0; m_cd = CD; m_ph = M_COOL; end
                  M_COOL: if (frame_start) begin
                     m_cd--;
                     if (m_cd == 0) begin e_busy = 0; m_ph = M_IDLE; end
                  end
                  default: m_ph = M_IDLE;
               endcase
            end
         end
      end
   end

   // Per-cycle comparison plus event monitors on the DUT outputs.
   int  n_shot = 0, n_hit = 0, n_miss = 0, black_cycles = 0, target_cycles = 0;
   int  fs_at_result = 0, fs_at_idle = 0;
   bit  busy_d = 0;
   initial begin
      logic [5:0] act6, exp6;
      forever begin
         @(negedge clk);
         act6 = {black_screen, target_screen, shot, hit, miss, busy};
         exp6 = {e_black, e_target, e_shot, e_hit, e_miss, e_busy};
         check("cycle outputs {blk,tgt,shot,hit,miss,busy}", 32'(act6), 32'(exp6));
         if (shot) n_shot++;
         if (hit) n_hit++;
         if (miss) n_miss++;
         if (black_screen) black_cycles++;
         if (target_screen) target_cycles++;
         if (hit || miss) fs_at_result = m_fs_total;
         if (busy_d && !busy) fs_at_idle = m_fs_total;
         busy_d = busy;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_release(input int hold, input int gap);
      @(negedge clk);
      gun_trigger = 1'b0;
      cycles(hold);
      gun_trigger = 1'b1;
      cycles(gap);
   endtask

   // sel: 0 black_screen, 1 target_screen, 2 hit|miss, 3 busy low
   task automatic wait_until(input int sel, input int budget, input string nm);
      bit ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(negedge clk);
         case (sel)
            0: ok = black_screen;
            1: ok = target_screen;
            2: ok = hit || miss;
            default: ok = !busy;
         endcase
      end
      check(nm, 32'(ok), 32'd1);
      cycles(2);
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0, h0, m0, b0, t0;
      cycles(3);
      check("reset outputs", 32'({black_screen, target_screen, shot, hit, miss, busy}), 32'd0);
      #2 rst = 1'b1;
      cycles(40);

      // Bounce filter, then a hit
      s0 = n_shot; h0 = n_hit; m0 = n_miss;
      repeat (3) begin
         gun_trigger = 1'b0; cycles(10);
         gun_trigger = 1'b1; cycles(10);
      end
      check("bounce glitches give no shot", 32'(n_shot - s0), 32'd0);
      gun_trigger = 1'b0; cycles(40);
      gun_trigger = 1'b1;
      check("held press gives one shot", 32'(n_shot - s0), 32'd1);
      b0 = black_cycles; t0 = target_cycles;
      wait_until(0, 1100, "black_screen rises");
      wait_until(1, 1100, "target_screen rises");
      cycles(300);
      gun_photodetector = 1'b1; cycles(10);
      gun_photodetector = 1'b0;
      wait_until(2, 1100, "hit result arrives");
      check("hit count", 32'(n_hit - h0), 32'd1);
      check("no miss on hit", 32'(n_miss - m0), 32'd0);
      check("black frame length", 32'(black_cycles - b0), 32'd1000);
      check("target frame length", 32'(target_cycles - t0), 32'd1000);
      wait_until(3, 2200, "busy falls after hit");

      // Miss: dark in both frames
      h0 = n_hit; m0 = n_miss;
      press_release(40, 20);
      wait_until(2, 3500, "dark miss result");
      check("dark miss count", 32'(n_miss - m0), 32'd1);
      check("dark no hit", 32'(n_hit - h0), 32'd0);
      wait_until(3, 2200, "busy falls after dark miss");

      // Miss: light bursts shorter than the threshold
      m0 = n_miss;
      press_release(40, 20);
      wait_until(1, 2200, "target_screen for short pulses");
      repeat (20) begin
         gun_photodetector = 1'b1; cycles(3);
         gun_photodetector = 1'b0; cycles(5);
      end
      wait_until(2, 1100, "short pulse result");
      check("short pulse miss count", 32'(n_miss - m0), 32'd1);
      wait_until(3, 2200, "busy falls after short pulses");

      // Cheat: light throughout
      h0 = n_hit; m0 = n_miss;
      gun_photodetector = 1'b1;
      press_release(40, 20);
      wait_until(2, 3500, "cheat result");
      check("cheat miss count", 32'(n_miss - m0), 32'd1);
      check("cheat no hit", 32'(n_hit - h0), 32'd0);
      gun_photodetector = 1'b0;
      wait_until(3, 2200, "busy falls after cheat");

      // Presses during TARGET and COOLDOWN are dropped
      s0 = n_shot;
      press_release(40, 20);
      wait_until(1, 2200, "target_screen for cooldown test");
      press_release(40, 20);
      wait_until(2, 1100, "cooldown test result");
      press_release(40, 20);
      check("presses while busy dropped", 32'(n_shot - s0), 32'd1);
      wait_until(3, 2500, "busy falls after cooldown");
      check("frame_starts from result to idle", 32'(fs_at_idle - fs_at_result), 32'd2);
      press_release(40, 20);
      check("press after cooldown accepted", 32'(n_shot - s0), 32'd2);

      // Abort during BLACK
      h0 = n_hit; m0 = n_miss;
      wait_until(0, 1100, "black_screen before abort");
      cycles(100);
      enable = 1'b0;
      cycles(2);
      check("abort clears black_screen", 32'(black_screen), 32'd0);
      check("abort clears busy", 32'(busy), 32'd0);
      enable = 1'b1;
      cycles(2500);
      check("abort gives no result", 32'((n_hit - h0) + (n_miss - m0)), 32'd0);

      // Press with enable low is dropped, not queued
      s0 = n_shot;
      enable = 1'b0;
      press_release(40, 20);
      enable = 1'b1;
      cycles(40);
      check("press with enable low dropped", 32'(n_shot - s0), 32'd0);

      // Trigger held through reset
      s0 = n_shot; m0 = n_miss;
      gun_trigger = 1'b0;
      #2 rst = 1'b0;
      cycles(5);
      #2 rst = 1'b1;
      cycles(100);
      check("held through reset no shot", 32'(n_shot - s0), 32'd0);
      gun_trigger = 1'b1; cycles(40);
      gun_trigger = 1'b0; cycles(40);
      gun_trigger = 1'b1;
      check("release then press fires", 32'(n_shot - s0), 32'd1);
      wait_until(2, 3500, "post-reset result");
      check("post-reset miss", 32'(n_miss - m0), 32'd1);
      wait_until(3, 2200, "busy falls after post-reset shot");

      // Totals, against both the DUT and the reference model
      check("total shots", 32'(n_shot), 32'd7);
      check("total hits", 32'(n_hit), 32'd1);
      check("total misses", 32'(n_miss), 32'd5);
      check("model shots", 32'(m_n_shot), 32'd7);
      check("model hits", 32'(m_n_hit), 32'd1);
      check("model misses", 32'(m_n_miss), 32'd5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
